sdram_port_scheduler: RTL

- Parametrised N-write / M-read port scheduler for the SDRAM controller's front end.
- Replaces the fixed 2W/2R auto read/write logic.
- Tracks per-port burst address and length, decides which port's FIFO is served next, issues one burst command at a time to the SDRAM burst engine, and advances or wraps that port's address when the burst completes.
- Adds round-robin arbitration, a selectable fixed-priority mode, and an explicit req/ack/done handshake.

---
 rtl/sdram_port_scheduler.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_scheduler.sv
// N-write / M-read SDRAM burst scheduler: arbitrates port FIFOs,
// issues one burst command at a time, advances/wraps port addresses.
// Ports: CLK/RESET_N; per-port start/max/len/load and FIFO levels in;
// cmd_req/wr/addr/len/port out with cmd_ack/cmd_done back; wr_sel/rd_sel
// one-hot data-path selects held for the life of the burst.
module sdram_port_scheduler #(
  parameter int NUM_WR  = 2,
  parameter int NUM_RD  = 2,
  parameter int ASIZE   = 22,
  parameter int LSIZE   = 9,
  parameter int DEF_LEN = 256,
  parameter int RR_MODE = 1,
  localparam int NP = NUM_WR + NUM_RD,
  localparam int PW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NP*ASIZE-1:0]     port_start,
  input  logic [NP*ASIZE-1:0]     port_max,
  input  logic [NP*LSIZE-1:0]     port_len,
  input  logic [NP-1:0]           port_load,
  input  logic [NUM_WR*LSIZE-1:0] wr_level,
  input  logic [NUM_RD*LSIZE-1:0] rd_level,
  output logic                    cmd_req,
  output logic                    cmd_wr,
  output logic [ASIZE-1:0]        cmd_addr,
  output logic [LSIZE-1:0]        cmd_len,
  output logic [PW-1:0]           cmd_port,
  input  logic                    cmd_ack,
  input  logic                    cmd_done,
  output logic [NUM_WR-1:0]       wr_sel,
  output logic [NUM_RD-1:0]       rd_sel
);

  typedef enum logic [1:0] {
    IDLE, REQ, BUSY, UPD
  } state_t;

  state_t state_q, state_d;

  logic [ASIZE-1:0]  addr_q [NP];
  logic [ASIZE-1:0]  addr_d [NP];
  logic [LSIZE-1:0]  len_q  [NP];
  logic [LSIZE-1:0]  len_d  [NP];
  logic [PW-1:0]     rr_q, rr_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ASIZE-1:0]  caddr_q, caddr_d;
  logic [LSIZE-1:0]  clen_q, clen_d;
  logic [PW-1:0]     port_q, port_d;
  logic [NUM_WR-1:0] wsel_q, wsel_d;
  logic [NUM_RD-1:0] rsel_q, rsel_d;
  // Granted port was reloaded during its burst: keep the loaded address.
  logic              ldh_q, ldh_d;

  logic [NP-1:0]     elig;
  logic              found;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     idx;
  logic [ASIZE:0]    nxt;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      elig[i] = (wr_level[i*LSIZE +: LSIZE] >= len_q[i]) &&
                (len_q[i] != '0);
    end
    for (int j = 0; j < NUM_RD; j++) begin
      elig[NUM_WR+j] =
        (rd_level[j*LSIZE +: LSIZE] < len_q[NUM_WR+j]) &&
        (len_q[NUM_WR+j] != '0);
    end
  end

  // First eligible port in search order wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NP; k++) begin
      if (RR_MODE != 0) begin
        idx = PW'((int'(rr_q) + k) % NP);
      end else begin
        idx = PW'(k);
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    req_d   = req_q;
    wr_d    = wr_q;
    caddr_d = caddr_q;
    clen_d  = clen_q;
    port_d  = port_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    ldh_d   = ldh_q;
    for (int i = 0; i < NP; i++) begin
      addr_d[i] = addr_q[i];
      len_d[i]  = len_q[i];
    end
    // Extra bit keeps addr+len from wrapping before the max compare.
    nxt = {1'b0, addr_q[port_q]} + (ASIZE+1)'(len_q[port_q]);

    unique case (state_q)
      IDLE: begin
        if (!(|port_load) && found) begin
          req_d   = 1'b1;
          wr_d    = (int'(gnt) < NUM_WR);
          caddr_d = addr_q[gnt];
          clen_d  = len_q[gnt];
          port_d  = gnt;
          ldh_d   = 1'b0;
          for (int i = 0; i < NUM_WR; i++) begin
            wsel_d[i] = (int'(gnt) == i);
          end
          for (int j = 0; j < NUM_RD; j++) begin
            rsel_d[j] = (int'(gnt) == NUM_WR + j);
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (port_load[port_q]) ldh_d = 1'b1;
        // A done arriving with the ack belongs to a later cycle.
        if (cmd_ack) begin
          req_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (port_load[port_q]) ldh_d = 1'b1;
        if (cmd_done) state_d = UPD;
      end
      UPD: begin
        if (!ldh_q) begin
          if (nxt >= {1'b0, port_max[port_q*ASIZE +: ASIZE]}) begin
            addr_d[port_q] = port_start[port_q*ASIZE +: ASIZE];
          end else begin
            addr_d[port_q] = nxt[ASIZE-1:0];
          end
        end
        wsel_d = '0;
        rsel_d = '0;
        if (int'(port_q) == NP - 1) begin
          rr_d = '0;
        end else begin
          rr_d = port_q + PW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Loads win over the completion update.
    for (int i = 0; i < NP; i++) begin
      if (port_load[i]) begin
        addr_d[i] = port_start[i*ASIZE +: ASIZE];
        len_d[i]  = port_len[i*LSIZE +: LSIZE];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rr_q    <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      caddr_q <= '0;
      clen_q  <= '0;
      port_q  <= '0;
      wsel_q  <= '0;
      rsel_q  <= '0;
      ldh_q   <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= LSIZE'(DEF_LEN);
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      caddr_q <= caddr_d;
      clen_q  <= clen_d;
      port_q  <= port_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      ldh_q   <= ldh_d;
      for (int i = 0; i < NP; i++) begin
        addr_q[i] <= addr_d[i];
        len_q[i]  <= len_d[i];
      end
    end
  end

  assign cmd_req  = req_q;
  assign cmd_wr   = wr_q;
  assign cmd_addr = caddr_q;
  assign cmd_len  = clen_q;
  assign cmd_port = port_q;
  assign wr_sel   = wsel_q;
  assign rd_sel   = rsel_q;

endmodule
